// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory loader
// Purpose: loader FSM state enum and frame byte constants.
// Ports: none (package).
package imem_pkg;

    localparam int         LD_BYTE_W = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        CNT_LO,
        CNT_HI,
        DATA_LO,
        DATA_HI,
        CSUM,
        DONE
    } imem_ld_state_t;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction word storage, one sync write port, one async read port
// Purpose: 2^DEPTH_LOG2 x IWIDTH storage. Contents survive reset; simulation
//          starts from all-zero contents.
// Ports:
//   clk_i            clock
//   we_i             write enable, write lands at the rising edge
//   waddr_i/wdata_i  write address and word
//   raddr_i/rdata_o  read address and combinational read word
module imem_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int IWIDTH     = 16
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [IWIDTH-1:0]     wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [IWIDTH-1:0]     rdata_o
);

    logic [IWIDTH-1:0] mem_q [2**DEPTH_LOG2] = '{default: '0};

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A read of the address being written returns the old word until the edge.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory responder with host byte-stream program loader
// Purpose: zero-latency fetch responder for the cpu, plus a frame loader that
//          writes program words from the host link and holds the cpu in reset
//          while a frame is being loaded.
// Optional feature macro: IMEM_CHECKSUM_EN (trailing CSUM byte and sticky ld_err).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   iaddr, idata                fetch address in, instruction word out (combinational)
//   ld_data, ld_valid, ld_ready loader byte stream, transfer on ld_valid & ld_ready
//   cpu_hold                    high keeps the cpu in reset
//   ld_busy                     a frame is in progress
//   ld_err                      sticky checksum error (tied 0 without IMEM_CHECKSUM_EN)
module imem_loader
    import imem_pkg::*;
#(
    parameter int IADDRWIDTH    = 16,
    parameter int IWIDTH        = 16,
    parameter int DEPTH_LOG2    = 10,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IADDRWIDTH-1:0] iaddr,
    output logic [IWIDTH-1:0]     idata,
    input  logic [LD_BYTE_W-1:0]  ld_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    output logic                  cpu_hold,
    output logic                  ld_busy,
    output logic                  ld_err
);

    // State following the last payload byte, or CNT_HI of an empty frame.
`ifdef IMEM_CHECKSUM_EN
    localparam imem_ld_state_t TAIL_STATE = CSUM;
`else
    localparam imem_ld_state_t TAIL_STATE = DONE;
`endif

    imem_ld_state_t state_q, state_d;
    logic [15:0]    addr_q, addr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [7:0]     lo_q, lo_d;
    logic           hold_q, hold_d;
    logic           fire;
    logic           mem_we;

`ifdef IMEM_CHECKSUM_EN
    logic [7:0]     sum_q, sum_d;
    logic           err_q, err_d;
`endif

    // Address bits above the storage depth are ignored on both ports.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iaddr[IADDRWIDTH-1:DEPTH_LOG2], addr_q[15:DEPTH_LOG2]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hold_q  <= HOLD_AT_RESET;
`ifdef IMEM_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hold_q  <= hold_d;
`ifdef IMEM_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hold_d  = hold_q;
`ifdef IMEM_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (fire && ld_data == SYNC_BYTE) begin
                    state_d = ADDR_LO;
                    hold_d  = 1'b1;
`ifdef IMEM_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            ADDR_LO: begin
                if (fire) begin
                    addr_d[7:0] = ld_data;
                    state_d     = ADDR_HI;
                end
            end
            ADDR_HI: begin
                if (fire) begin
                    addr_d[15:8] = ld_data;
                    state_d      = CNT_LO;
                end
            end
            CNT_LO: begin
                if (fire) begin
                    cnt_d[7:0] = ld_data;
                    state_d    = CNT_HI;
                end
            end
            CNT_HI: begin
                if (fire) begin
                    cnt_d   = {ld_data, cnt_q[7:0]};
                    state_d = ({ld_data, cnt_q[7:0]} == 16'd0) ? TAIL_STATE : DATA_LO;
                end
            end
            DATA_LO: begin
                if (fire) begin
                    lo_d    = ld_data;
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (fire) begin
                    addr_d  = addr_q + 16'd1;
                    cnt_d   = cnt_q - 16'd1;
                    state_d = (cnt_q == 16'd1) ? TAIL_STATE : DATA_LO;
                end
            end
`ifdef IMEM_CHECKSUM_EN
            CSUM: begin
                if (fire) begin
                    // Sum over every byte after sync, including this one, must be zero.
                    err_d   = (8'(sum_q + ld_data) != 8'h00);
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
`ifdef IMEM_CHECKSUM_EN
                hold_d  = err_q;
`else
                hold_d  = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef IMEM_CHECKSUM_EN
        if (fire && state_q inside {ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA_LO, DATA_HI}) begin
            sum_d = 8'(sum_q + ld_data);
        end
`endif
    end

    // Output logic
    always_comb begin
        ld_ready = ~rst && (state_q != DONE);
        ld_busy  = (state_q != IDLE);
        fire     = ld_valid && ld_ready;
        mem_we   = fire && (state_q == DATA_HI);
    end

    assign cpu_hold = hold_q;
`ifdef IMEM_CHECKSUM_EN
    assign ld_err   = err_q;
`else
    assign ld_err   = 1'b0;
`endif

    imem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .IWIDTH     (IWIDTH)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (addr_q[DEPTH_LOG2-1:0]),
        .wdata_i ({ld_data, lo_q}),
        .raddr_i (iaddr[DEPTH_LOG2-1:0]),
        .rdata_o (idata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] iaddr = '0;
    logic [15:0] idata;
    logic [7:0]  ld_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic        cpu_hold;
    logic        ld_busy;
    logic        ld_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ref_mem [1024];
    logic [15:0] fw [$];
    int          wr_idx [$];

    typedef struct {
        logic [15:0] ia;
        logic [15:0] exp;
    } rdvec_t;
    rdvec_t tbl [7];

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .iaddr    (iaddr),
        .idata    (idata),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .cpu_hold (cpu_hold),
        .ld_busy  (ld_busy),
        .ld_err   (ld_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered between posedge+1 and the next negedge; leaves at posedge+1 after the transfer.
    task automatic send_byte(input logic [7:0] b, input bit chk_rd, input logic [15:0] old_w);
        int waited = 0;
        ld_data  = b;
        ld_valid = 1'b1;
        @(negedge clk);
        while (!ld_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ld_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_wait: got no ld_ready, expected ld_ready within 20 cycles");
        end
        if (chk_rd) chk("read_old_in_write_cycle", idata, old_w);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ld_valid = 1'b0;
        #1;
        chk("rst_ready_low", ld_ready, 0);
        @(posedge clk);
        #1;
        chk("rst_busy", ld_busy, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_err", ld_err, 0);
        chk("rst_ready_low2", ld_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ld_ready, 1);
        chk("post_rst_hold", cpu_hold, 1);
        chk("post_rst_busy", ld_busy, 0);
    endtask

    // Sends a frame carrying the words in fw, updating the reference memory.
    task automatic send_frame(input logic [15:0] addr, input bit bad, input int max_gap);
        logic [7:0]  fb [$];
        logic [7:0]  sum;
        logic [15:0] waddr;
        logic [15:0] old_w;
        logic [9:0]  idx;
        bit          exp_err;
        bit          last_hi;
        int          n;
        int          gap;
        n = fw.size();
        fb = {};
        fb.push_back(8'hA5);
        fb.push_back(addr[7:0]);
        fb.push_back(addr[15:8]);
        fb.push_back(8'(n));
        fb.push_back(8'(n >> 8));
        foreach (fw[k]) begin
            fb.push_back(fw[k][7:0]);
            fb.push_back(fw[k][15:8]);
        end
        sum = 8'h00;
        for (int i = 1; i < fb.size(); i++) sum = 8'(sum + fb[i]);
`ifdef IMEM_CHECKSUM_EN
        fb.push_back(8'(8'h00 - sum) ^ (bad ? 8'h5A : 8'h00));
        exp_err = bad;
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < fb.size(); i++) begin
            gap = int'($urandom_range(max_gap, 0));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            last_hi = (n > 0) && (i == 4 + 2 * n);
            old_w   = '0;
            if (last_hi) begin
                waddr = 16'(addr + 16'(n - 1));
                iaddr = waddr;
                old_w = ref_mem[waddr[9:0]];
            end
            send_byte(fb[i], last_hi, old_w);
            if (i == 0) begin
                chk("busy_after_sync", ld_busy, 1);
                chk("hold_after_sync", cpu_hold, 1);
            end
            if (i >= 6 && i < 5 + 2 * n && ((i - 6) % 2 == 0)) begin
                idx = 10'(addr + 16'((i - 6) / 2));
                ref_mem[idx] = {fb[i], fb[i-1]};
                wr_idx.push_back(int'(idx));
            end
            if (last_hi) chk("read_new_after_write", idata, ref_mem[waddr[9:0]]);
        end
        chk("done_ready_low", ld_ready, 0);
        chk("done_busy", ld_busy, 1);
        @(posedge clk);
        #1;
        chk("idle_busy", ld_busy, 0);
        chk("idle_ready", ld_ready, 1);
        chk("idle_hold", cpu_hold, exp_err);
        chk("idle_err", ld_err, exp_err);
    endtask

    initial begin
        logic [7:0]  j;
        logic [15:0] ra;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

        tbl[0] = '{16'h0001, 16'h5678};
        tbl[1] = '{16'h03FF, 16'hAAA1};
        tbl[2] = '{16'h0000, 16'hBBB2};
        tbl[3] = '{16'h0400, 16'hBBB2};
        tbl[4] = '{16'hFC01, 16'h5678};
        tbl[5] = '{16'h0005, 16'h0000};
        tbl[6] = '{16'h07FF, 16'hAAA1};

        do_reset();
        iaddr = 16'h0000;
        #1;
        chk("initial_mem_zero", idata, 0);

        // Junk in IDLE is discarded without starting a frame.
        send_byte(8'h00, 1'b0, '0);
        chk("junk00_busy", ld_busy, 0);
        send_byte(8'h11, 1'b0, '0);
        chk("junk11_busy", ld_busy, 0);
        chk("junk_hold", cpu_hold, 1);

        fw = {16'h1234, 16'h5678};
        send_frame(16'h0000, 1'b0, 0);
        iaddr = 16'h0000;
        #1;
        chk("frame1_word0", idata, 16'h1234);

        // Wrap past the top of storage.
        fw = {16'hAAA1, 16'hBBB2};
        send_frame(16'h03FF, 1'b0, 2);

        // Empty frame: no writes.
        fw = {};
        send_frame(16'h0005, 1'b0, 1);

        for (int i = 0; i < 7; i++) begin
            iaddr = tbl[i].ia;
            #1;
            chk($sformatf("table_read_%0h", tbl[i].ia), idata, tbl[i].exp);
        end

        // Reset after ADDR_HI abandons the frame.
        send_byte(8'hA5, 1'b0, '0);
        send_byte(8'h10, 1'b0, '0);
        send_byte(8'h00, 1'b0, '0);
        chk("midframe_busy", ld_busy, 1);
        do_reset();
        fw = {16'hC0DE};
        send_frame(16'h0010, 1'b0, 1);
        iaddr = 16'h0010;
        #1;
        chk("after_reset_load", idata, 16'hC0DE);

`ifdef IMEM_CHECKSUM_EN
        fw = {16'hDEAD};
        send_frame(16'h0020, 1'b1, 0);
        chk("bad_csum_hold_stays", cpu_hold, 1);
        fw = {16'hBEEF};
        send_frame(16'h0021, 1'b0, 0);
        chk("good_csum_clears_err", ld_err, 0);
`endif

        // Randomized frames against the reference memory.
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(2, 0)) begin
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h5A;
                send_byte(j, 1'b0, '0);
                chk("rand_junk_busy", ld_busy, 0);
            end
            fw = {};
            repeat ($urandom_range(5, 0)) fw.push_back(16'($urandom));
            send_frame(16'($urandom), ($urandom_range(3, 0) == 0), 3);
        end
        foreach (wr_idx[k]) begin
            iaddr = 16'($urandom_range(63, 0) << 10) | 16'(wr_idx[k]);
            #1;
            chk("rand_written_read", idata, ref_mem[wr_idx[k]]);
        end
        for (int k = 0; k < 16; k++) begin
            ra = 16'($urandom);
            iaddr = ra;
            #1;
            chk("rand_any_read", idata, ref_mem[ra[9:0]]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
